// File: rtl/cpu_pkg.sv
// Shared types for the instruction issue path: sequencer state, I-type instruction word, x0 index.
// No logic; imported by the FIFO and the sequencer.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DECODE,
    EXECUTE,
    WRITEBACK
  } seq_state_t;

  typedef struct packed {
    logic [2:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [11:0] imm12;
  } instr_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // x0 is hardwired to zero, so a write to it must never be strobed.
  function automatic logic writes_reg(input logic [4:0] rd);
    return rd != REG_ZERO;
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// Instruction buffer: DEPTH-entry circular FIFO, head visible combinationally, one-cycle push-to-head.
// push is ignored while full and pop while empty; full/empty come from a registered count.
module instr_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   push,
  input  instr_t push_data,
  input  logic   pop,
  output instr_t head,
  output logic   full,
  output logic   empty
);

  localparam int AW = $clog2(DEPTH);

  instr_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = count == (AW+1)'(DEPTH);
  assign empty   = count == '0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage is not reset: the count alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/exec_sequencer.sv
// Serial issue controller: DECODE/EXECUTE/WRITEBACK per instruction, 3 cycles each, first write 4 cycles after acceptance.
// in_ready = !full from the registered count, so a slot freed by a pop is offered on the following cycle.
module exec_sequencer
  import cpu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_opcode,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [11:0]      in_imm12,
  output logic [4:0]       rf_read_addr,
  output logic [4:0]       rf_write_addr,
  output logic             rf_write_en,
  output logic [2:0]       alu_op,
  output logic [WIDTH-1:0] imm_data,
  output logic             busy,
  output logic             retire,
  output logic [CNT_W-1:0] retired_count
);

  seq_state_t state;
  instr_t     in_instr;
  instr_t     head;
  instr_t     cur;
  logic       full;
  logic       empty;
  logic       pop;

  assign in_instr = '{opcode: in_opcode, rd: in_rd, rs1: in_rs1, imm12: in_imm12};
  assign in_ready = !full;
  assign pop      = !empty && (state == IDLE || state == WRITEBACK);
  assign busy     = (state != IDLE) || !empty;

  instr_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (in_valid),
    .push_data(in_instr),
    .pop      (pop),
    .head     (head),
    .full     (full),
    .empty    (empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      cur           <= '0;
      rf_read_addr  <= '0;
      rf_write_addr <= '0;
      rf_write_en   <= 1'b0;
      alu_op        <= '0;
      imm_data      <= '0;
      retire        <= 1'b0;
      retired_count <= '0;
    end else begin
      rf_write_en <= 1'b0;
      retire      <= 1'b0;
      case (state)
        IDLE, WRITEBACK: begin
          // Operands are launched straight from the head so they are already valid in DECODE.
          if (!empty) begin
            cur          <= head;
            rf_read_addr <= head.rs1;
            alu_op       <= head.opcode;
            imm_data     <= WIDTH'(head.imm12);
            state        <= DECODE;
          end else begin
            state <= IDLE;
          end
        end
        DECODE: begin
          state <= EXECUTE;
        end
        EXECUTE: begin
          // Re-assert from the latched instruction so operands stay pinned through the write.
          rf_read_addr  <= cur.rs1;
          alu_op        <= cur.opcode;
          imm_data      <= WIDTH'(cur.imm12);
          rf_write_addr <= cur.rd;
          rf_write_en   <= writes_reg(cur.rd);
          retire        <= 1'b1;
          retired_count <= retired_count + CNT_W'(1);
          state         <= WRITEBACK;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
